int_ram_arb: RTL and testbench

Multi-requester front end for the RSA accelerator's internal operand RAM (`int_ram`, true dual-port, M10K).
- Accepts word read/write requests from up to `N_REQ` clients, such as the host load/unload path and the Montgomery multiplier operand fetch/writeback.
- Grants up to two requests per cycle, one per RAM port, with round-robin fairness.
- Blocks same-address hazards.
- Returns read data to the owning requester with a fixed latency.

---
 rtl/rsa_mem_pkg.sv | 37 +++
 rtl/int_ram.sv | 40 ++++
 rtl/int_ram_arb.sv | 175 +++++++++++++++++
 tb/tb_int_ram_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_mem_pkg.sv
// Shared types and default sizes for the RSA accelerator operand memory path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package rsa_mem_pkg;

    // Default geometry of the operand RAM and its requester count.
    localparam int DEF_MEM_WIDTH = 8;
    localparam int DEF_MEM_WORDS = 129;
    localparam int DEF_N_REQ     = 3;
    localparam int DEF_ADDR_W    = $clog2(DEF_MEM_WORDS);

    // Requester ids are carried at the width needed by the largest legal
    // requester count (8), so the tag type never depends on N_REQ.
    localparam int MAX_N_REQ = 8;
    localparam int TAG_ID_W  = $clog2(MAX_N_REQ);

    // One word access as presented to a RAM port. Field widths follow the
    // default geometry.
    typedef struct packed {
        logic                     we;
        logic [DEF_ADDR_W-1:0]    addr;
        logic [DEF_MEM_WIDTH-1:0] wdata;
    } ram_req_t;

    // Read-return tag travelling alongside the RAM read latency.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rsp_tag_t;

    // Two accesses may not share a cycle when they touch the same word and
    // either of them writes; two reads of one word are harmless.
    function automatic logic is_hazard(input ram_req_t a, input ram_req_t b);
        return (a.addr == b.addr) && (a.we || b.we);
    endfunction

endpackage

// File: rtl/int_ram.sv
// True dual-port operand RAM with registered address and registered output.
// Latency: read enabled in cycle T presents q in cycle T+2; writes land at the end of T.
// Backpressure: none; both ports accept one access every cycle.
//
// Ports: clk; per port x in {a,b}: addr_x, data_x (write data), wren_x,
// rden_x, q_x (read data). Contents are never reset.
module int_ram #(
    parameter  int MEM_WIDTH = 8,
    parameter  int MEM_WORDS = 129,
    localparam int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic [ADDR_W-1:0]    addr_a,
    input  logic [MEM_WIDTH-1:0] data_a,
    input  logic                 wren_a,
    input  logic                 rden_a,
    output logic [MEM_WIDTH-1:0] q_a,
    input  logic [ADDR_W-1:0]    addr_b,
    input  logic [MEM_WIDTH-1:0] data_b,
    input  logic                 wren_b,
    input  logic                 rden_b,
    output logic [MEM_WIDTH-1:0] q_b
);

    logic [MEM_WIDTH-1:0] mem [MEM_WORDS];
    logic [ADDR_W-1:0]    raddr_a;
    logic [ADDR_W-1:0]    raddr_b;

    // Both ports live in one process so the array has a single writer. The
    // arbiter never lets both ports write one word in the same cycle.
    always_ff @(posedge clk) begin
        if (wren_a) mem[addr_a] <= data_a;
        if (wren_b) mem[addr_b] <= data_b;
        if (rden_a) raddr_a <= addr_a;
        if (rden_b) raddr_b <= addr_b;
        q_a <= mem[raddr_a];
        q_b <= mem[raddr_b];
    end

endmodule

// File: rtl/int_ram_arb.sv
// Round-robin front end granting up to two word accesses per cycle onto int_ram.
// Latency: req_ready is combinational; read data returns to its requester 2 cycles after acceptance.
// Backpressure: req_ready low means retry with held request; responses cannot be stalled.
//
// Ports: clk, reset_n (async, active low); per requester i: req_valid[i],
// req_we[i], req_addr/req_wdata slice i, req_ready[i]; rsp_valid[i] pulses
// for one cycle with rsp_data slice i carrying the read word.
module int_ram_arb
    import rsa_mem_pkg::*;
#(
    parameter  int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter  int MEM_WORDS = DEF_MEM_WORDS,
    parameter  int N_REQ     = DEF_N_REQ,
    localparam int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*MEM_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [N_REQ*MEM_WIDTH-1:0] rsp_data
);

    localparam int ID_W = $clog2(N_REQ);

    // Unpacked view of every requester's access.
    ram_req_t req [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req[i].we    = req_we[i];
            req[i].addr  = req_addr[i*ADDR_W +: ADDR_W];
            req[i].wdata = req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Scan from rr_ptr: first valid candidate takes port 0 (RAM port 1),
    // the next non-conflicting valid candidate takes port 1 (RAM port 2).
    // ------------------------------------------------------------------
    logic [ID_W-1:0] rr_ptr;
    logic            g1_vld;
    logic [ID_W-1:0] g1_idx;
    logic            g2_vld;
    logic [ID_W-1:0] g2_idx;
    logic [ID_W-1:0] cand;
    int              scan_pos;

    always_comb begin
        g1_vld   = 1'b0;
        g1_idx   = '0;
        g2_vld   = 1'b0;
        g2_idx   = '0;
        cand     = '0;
        scan_pos = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_pos = int'(rr_ptr) + k;
            if (scan_pos >= N_REQ) scan_pos = scan_pos - N_REQ;
            cand = ID_W'(scan_pos);
            if (req_valid[cand]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = cand;
                end else if (!g2_vld && !is_hazard(req[g1_idx], req[cand])) begin
                    g2_vld = 1'b1;
                    g2_idx = cand;
                end
            end
        end
    end

    // Reset masks all grants so nothing is accepted or driven into the RAM.
    logic [N_REQ-1:0] grant;

    always_comb begin
        grant = '0;
        if (g1_vld) grant[g1_idx] = 1'b1;
        if (g2_vld) grant[g2_idx] = 1'b1;
        req_ready = reset_n ? grant : '0;
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: one past the last requester granted this cycle.
    // ------------------------------------------------------------------
    logic [ID_W-1:0] last_idx;
    logic [ID_W-1:0] rr_nxt;

    always_comb begin
        last_idx = g2_vld ? g2_idx : g1_idx;
        rr_nxt   = (last_idx == ID_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (g1_vld) begin
            rr_ptr <= rr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // RAM port drive.
    // ------------------------------------------------------------------
    logic            port_en  [2];
    ram_req_t        port_req [2];
    logic [ID_W-1:0] port_idx [2];
    logic [MEM_WIDTH-1:0] port_q [2];

    always_comb begin
        port_en[0]  = g1_vld && reset_n;
        port_en[1]  = g2_vld && reset_n;
        port_idx[0] = g1_idx;
        port_idx[1] = g2_idx;
        port_req[0] = req[g1_idx];
        port_req[1] = req[g2_idx];
    end

    int_ram #(
        .MEM_WIDTH (MEM_WIDTH),
        .MEM_WORDS (MEM_WORDS)
    ) u_int_ram (
        .clk    (clk),
        .addr_a (port_req[0].addr),
        .data_a (port_req[0].wdata),
        .wren_a (port_en[0] && port_req[0].we),
        .rden_a (port_en[0] && !port_req[0].we),
        .q_a    (port_q[0]),
        .addr_b (port_req[1].addr),
        .data_b (port_req[1].wdata),
        .wren_b (port_en[1] && port_req[1].we),
        .rden_b (port_en[1] && !port_req[1].we),
        .q_b    (port_q[1])
    );

    // ------------------------------------------------------------------
    // Tag pipeline: one tag register per RAM register stage, so the second
    // tag lines up with the registered RAM output. Only reads load a tag.
    // ------------------------------------------------------------------
    rsp_tag_t tag_s0 [2];
    rsp_tag_t tag_s1 [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                tag_s0[p] <= '0;
                tag_s1[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                tag_s0[p].valid <= port_en[p] && !port_req[p].we;
                tag_s0[p].id    <= TAG_ID_W'(port_idx[p]);
                tag_s1[p]       <= tag_s0[p];
            end
        end
    end

    // Response fan-out. The two ports never return to the same requester in
    // one cycle because a requester is granted at most once per cycle.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (tag_s1[p].valid && (tag_s1[p].id == TAG_ID_W'(i))) begin
                    rsp_valid[i]                      = 1'b1;
                    rsp_data[i*MEM_WIDTH +: MEM_WIDTH] = port_q[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_int_ram_arb.sv
// Directed bench for int_ram_arb at default geometry (8-bit words, 3 requesters).
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Backpressure: requesters hold their request until req_ready is seen.
module tb_int_ram_arb;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int NR = 3;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*W-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [NR*W-1:0] rsp_data;

    int n_vec;
    int n_err;

    int_ram_arb #(
        .MEM_WIDTH (W),
        .MEM_WORDS (129),
        .N_REQ     (NR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*W +: W]   = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    // Single-requester write; a lone request is always granted.
    task automatic write_word(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        drive(i, 1'b1, a, d);
        step();
        clear_all();
    endtask

    task automatic do_reset();
        clear_all();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 1'b0, 8'd1, 8'h00);
        drive(1, 1'b1, 8'd2, 8'h22);
        drive(2, 1'b0, 8'd3, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want %b", req_ready, 3'b000); end
        n_vec++;
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want %b", rsp_valid, 3'b000); end
        n_vec++;
        if (rsp_data !== 24'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want %h", rsp_data, 24'h0); end
        n_vec++;
        if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
        step();
        clear_all();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        write_word(0, 8'd5, 8'hA5);
        drive(1, 1'b0, 8'd5, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want %b", req_ready, 3'b010); end
        step();
        clear_all();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL single_t1_valid: got %b want %b", rsp_valid, 3'b000); end
        step();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b010) begin n_err++; $display("FAIL single_t2_valid: got %b want %b", rsp_valid, 3'b010); end
        n_vec++;
        if (rsp_data[15:8] !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want %h", rsp_data[15:8], 8'hA5); end
        step();
    endtask

    task automatic test_dual_grant();
        write_word(0, 8'd3, 8'h33);
        write_word(1, 8'd4, 8'h44);
        write_word(2, 8'd7, 8'h77);
        do_reset();
        drive(0, 1'b0, 8'd3, 8'h00);
        drive(1, 1'b0, 8'd4, 8'h00);
        drive(2, 1'b0, 8'd7, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b011) begin n_err++; $display("FAIL dual_ready_t0: got %b want %b", req_ready, 3'b011); end
        step();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL dual_ready_t1: got %b want %b", req_ready, 3'b100); end
        n_vec++;
        if (dut.rr_ptr !== 2'd2) begin n_err++; $display("FAIL dual_rr_ptr: got %0d want 2", dut.rr_ptr); end
        n_vec++;
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL dual_t1_valid: got %b want %b", rsp_valid, 3'b000); end
        step();
        clear_all();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b011) begin n_err++; $display("FAIL dual_t2_valid: got %b want %b", rsp_valid, 3'b011); end
        n_vec++;
        if (rsp_data[15:0] !== 16'h4433) begin n_err++; $display("FAIL dual_t2_data: got %h want %h", rsp_data[15:0], 16'h4433); end
        step();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b100) begin n_err++; $display("FAIL dual_t3_valid: got %b want %b", rsp_valid, 3'b100); end
        n_vec++;
        if (rsp_data[23:16] !== 8'h77) begin n_err++; $display("FAIL dual_t3_data: got %h want %h", rsp_data[23:16], 8'h77); end
        n_vec++;
        if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL dual_rr_wrap: got %0d want 0", dut.rr_ptr); end
        step();
    endtask

    task automatic test_hazard();
        drive(0, 1'b1, 8'd10, 8'h3C);
        drive(1, 1'b0, 8'd10, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b001) begin n_err++; $display("FAIL hazard_ready_t0: got %b want %b", req_ready, 3'b001); end
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL hazard_ready_t1: got %b want %b", req_ready, 3'b010); end
        step();
        clear_all();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL hazard_no_early_rsp: got %b want %b", rsp_valid, 3'b000); end
        step();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b010) begin n_err++; $display("FAIL hazard_rsp_valid: got %b want %b", rsp_valid, 3'b010); end
        n_vec++;
        if (rsp_data[15:8] !== 8'h3C) begin n_err++; $display("FAIL hazard_rsp_data: got %h want %h", rsp_data[15:8], 8'h3C); end
        step();
    endtask

    task automatic test_same_addr();
        write_word(0, 8'd20, 8'h11);
        drive(0, 1'b0, 8'd20, 8'h00);
        drive(2, 1'b0, 8'd20, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b101) begin n_err++; $display("FAIL same_ready: got %b want %b", req_ready, 3'b101); end
        step();
        clear_all();
        step();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b101) begin n_err++; $display("FAIL same_rsp_valid: got %b want %b", rsp_valid, 3'b101); end
        n_vec++;
        if ({rsp_data[23:16], rsp_data[7:0]} !== 16'h1111) begin
            n_err++;
            $display("FAIL same_rsp_data: got %h want %h", {rsp_data[23:16], rsp_data[7:0]}, 16'h1111);
        end
        step();
    endtask

    task automatic test_fairness();
        int grants [NR];
        int rsps   [NR];
        int waits  [NR];
        int max_w  [NR];
        do_reset();
        for (int i = 0; i < NR; i++) begin
            grants[i] = 0; rsps[i] = 0; waits[i] = 0; max_w[i] = 0;
        end
        drive(0, 1'b0, 8'd3, 8'h00);
        drive(1, 1'b0, 8'd4, 8'h00);
        drive(2, 1'b0, 8'd7, 8'h00);
        for (int c = 0; c < 32; c++) begin
            if (c == 30) clear_all();
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i]) rsps[i]++;
                if (req_valid[i]) begin
                    if (req_ready[i]) begin
                        grants[i]++;
                        waits[i] = 0;
                    end else begin
                        waits[i]++;
                        if (waits[i] > max_w[i]) max_w[i] = waits[i];
                    end
                end
            end
            step();
        end
        for (int i = 0; i < NR; i++) begin
            n_vec++;
            if (grants[i] != 20) begin n_err++; $display("FAIL fair_grants[%0d]: got %0d want 20", i, grants[i]); end
            n_vec++;
            if (max_w[i] != 1) begin n_err++; $display("FAIL fair_max_wait[%0d]: got %0d want 1", i, max_w[i]); end
            n_vec++;
            if (rsps[i] != 20) begin n_err++; $display("FAIL fair_rsps[%0d]: got %0d want 20", i, rsps[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        drive(1, 1'b0, 8'd5, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL mid_ready: got %b want %b", req_ready, 3'b010); end
        step();
        clear_all();
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid !== 3'b000) seen = 1'b1;
            step();
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 3'b000) seen = 1'b1;
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL mid_dropped_rsp: got %b want %b", seen, 1'b0); end
        n_vec++;
        if (dut.rr_ptr !== 2'd0) begin n_err++; $display("FAIL mid_rr_ptr: got %0d want 0", dut.rr_ptr); end
        step();
        drive(2, 1'b0, 8'd10, 8'h00);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL mid_new_ready: got %b want %b", req_ready, 3'b100); end
        step();
        clear_all();
        step();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 3'b100) begin n_err++; $display("FAIL mid_new_valid: got %b want %b", rsp_valid, 3'b100); end
        n_vec++;
        if (rsp_data[23:16] !== 8'h3C) begin n_err++; $display("FAIL mid_new_data: got %h want %h", rsp_data[23:16], 8'h3C); end
        step();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        step();
        test_reset();
        test_single_read();
        test_dual_grant();
        test_hazard();
        test_same_addr();
        test_fairness();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
